// File: rtl/fp_normalize_pipe.sv
// Two-stage post-add normalizer: leading-zero count in stage 1,
// shift / exponent adjust / zero-underflow-overflow flags in stage 2.
module fp_normalize_pipe #(
    parameter int SIZE_MAN = 28,
    parameter int SIZE_EXP = 8
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic                i_sign,
    input  logic [SIZE_EXP-1:0] i_exp,
    input  logic [SIZE_MAN:0]   i_man,
    output logic                o_valid,
    input  logic                i_ready,
    output logic                o_sign,
    output logic [SIZE_EXP-1:0] o_exp,
    output logic [SIZE_MAN-1:0] o_man,
    output logic                o_zero,
    output logic                o_underflow,
    output logic                o_overflow
);

    localparam int LZW = $clog2(SIZE_MAN);
    localparam logic [SIZE_EXP:0] EXP_ONES = {1'b0, {SIZE_EXP{1'b1}}};

    logic                s1_valid_q;
    logic                s1_sign_q;
    logic [SIZE_EXP-1:0] s1_exp_q;
    logic [SIZE_MAN:0]   s1_man_q;
    logic                s1_carry_q;
    logic                s1_zero_q;
    logic [LZW-1:0]      s1_lzc_q;
    logic [LZW-1:0]      s1_lzc_d;

    logic                s2_valid_q;
    logic                s2_sign_q;
    logic [SIZE_EXP-1:0] s2_exp_q;
    logic [SIZE_MAN-1:0] s2_man_q;
    logic                s2_zero_q;
    logic                s2_unf_q;
    logic                s2_ovf_q;

    logic [SIZE_EXP-1:0] s2_exp_d;
    logic [SIZE_MAN-1:0] s2_man_d;
    logic                s2_zero_d;
    logic                s2_unf_d;
    logic                s2_ovf_d;

    logic                s1_adv;
    logic                s2_adv;
    logic [SIZE_EXP:0]   exp_inc;
    logic [SIZE_EXP-1:0] lzc_ext;
    logic [SIZE_MAN-1:0] man_sh;

    assign s2_adv  = !s2_valid_q || i_ready;
    assign s1_adv  = !s1_valid_q || s2_adv;
    assign o_ready = s1_adv;

    // Highest set bit wins, so scan upward and let later hits override.
    always_comb begin
        s1_lzc_d = '0;
        for (int i = 0; i < SIZE_MAN; i++) begin
            if (i_man[i]) s1_lzc_d = LZW'(SIZE_MAN - 1 - i);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1_valid_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_exp_q   <= '0;
            s1_man_q   <= '0;
            s1_carry_q <= 1'b0;
            s1_zero_q  <= 1'b0;
            s1_lzc_q   <= '0;
        end else if (s1_adv) begin
            s1_valid_q <= i_valid;
            if (i_valid) begin
                s1_sign_q  <= i_sign;
                s1_exp_q   <= i_exp;
                s1_man_q   <= i_man;
                s1_carry_q <= i_man[SIZE_MAN];
                s1_zero_q  <= (i_man == '0);
                s1_lzc_q   <= s1_lzc_d;
            end
        end
    end

    assign exp_inc = {1'b0, s1_exp_q} + 1'b1;
    assign lzc_ext = {{(SIZE_EXP - LZW){1'b0}}, s1_lzc_q};
    assign man_sh  = s1_man_q[SIZE_MAN-1:0] << s1_lzc_q;

    always_comb begin
        s2_man_d  = '0;
        s2_exp_d  = '0;
        s2_zero_d = 1'b0;
        s2_unf_d  = 1'b0;
        s2_ovf_d  = 1'b0;
        if (s1_zero_q) begin
            s2_zero_d = 1'b1;
        end else if (s1_carry_q) begin
            // Wider increment catches all-ones input without wrapping.
            if (exp_inc >= EXP_ONES) begin
                s2_ovf_d = 1'b1;
                s2_exp_d = '1;
            end else begin
                s2_exp_d = exp_inc[SIZE_EXP-1:0];
                s2_man_d = {s1_man_q[SIZE_MAN:2],
                            s1_man_q[1] | s1_man_q[0]};
            end
        end else if (lzc_ext >= s1_exp_q) begin
            s2_unf_d = 1'b1;
        end else begin
            s2_exp_d = s1_exp_q - lzc_ext;
            s2_man_d = man_sh;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s2_valid_q <= 1'b0;
            s2_sign_q  <= 1'b0;
            s2_exp_q   <= '0;
            s2_man_q   <= '0;
            s2_zero_q  <= 1'b0;
            s2_unf_q   <= 1'b0;
            s2_ovf_q   <= 1'b0;
        end else if (s2_adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_sign_q <= s1_sign_q;
                s2_exp_q  <= s2_exp_d;
                s2_man_q  <= s2_man_d;
                s2_zero_q <= s2_zero_d;
                s2_unf_q  <= s2_unf_d;
                s2_ovf_q  <= s2_ovf_d;
            end
        end
    end

    assign o_valid     = s2_valid_q;
    assign o_sign      = s2_sign_q;
    assign o_exp       = s2_exp_q;
    assign o_man       = s2_man_q;
    assign o_zero      = s2_zero_q;
    assign o_underflow = s2_unf_q;
    assign o_overflow  = s2_ovf_q;

endmodule
